// File: rtl/cpu_types_pkg.sv
// Shared CPU types: machine word, fetch sequencer states and word-size constants.
package cpu_types_pkg;

   typedef logic [31:0] word_t;

   typedef enum logic [1:0] {
      BOOT,
      FETCH,
      DRAIN,
      HALTED
   } fetch_state_t;

   localparam int WORD_BYTES = 4;

   // Clears the byte-offset bits so every loaded PC is word aligned.
   function automatic word_t alignWord(input word_t addr);
      return addr & ~word_t'(WORD_BYTES - 1);
   endfunction

endpackage

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC and the imem read handshake, and
// hands one registered instruction at a time to decode.
module fetch_ctrl
   import cpu_types_pkg::*;
#(
   parameter word_t PC_INIT = 32'h0
) (
   input  logic        CLK,
   input  logic        nRST,
   input  logic        ihit,
   input  logic [31:0] imemload,
   output logic        imemREN,
   output logic [31:0] imemaddr,
   input  logic        stall,
   input  logic        redir_valid,
   input  logic [31:0] redir_target,
   input  logic        halt,
   output logic [31:0] instr,
   output logic        instr_valid,
   output logic        halted
);

   fetch_state_t state_q, state_d;
   word_t        pc_q, pc_d;
   word_t        instr_q, instr_d;
   logic         instrValid_q, instrValid_d;
   word_t        pendPc_q, pendPc_d;
   logic         pendHalt_q, pendHalt_d;

   logic         canAccept;
   logic         consumed;
   word_t        redirAligned;

   assign canAccept    = !instrValid_q || !stall;
   assign consumed     = instrValid_q && !stall;
   assign redirAligned = alignWord(redir_target);

   // pc only moves once an access completes, so in DRAIN it still names the
   // outstanding address.
   assign imemaddr    = pc_q;
   assign instr       = instr_q;
   assign instr_valid = instrValid_q;
   assign halted      = (state_q == HALTED);

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q      <= BOOT;
         pc_q         <= PC_INIT;
         instr_q      <= '0;
         instrValid_q <= 1'b0;
         pendPc_q     <= '0;
         pendHalt_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         instr_q      <= instr_d;
         instrValid_q <= instrValid_d;
         pendPc_q     <= pendPc_d;
         pendHalt_q   <= pendHalt_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      instr_d      = instr_q;
      instrValid_d = instrValid_q;
      pendPc_d     = pendPc_q;
      pendHalt_d   = pendHalt_q;
      imemREN      = 1'b0;

      case (state_q)
         BOOT: begin
            state_d = FETCH;
         end

         FETCH: begin
            imemREN = canAccept;
            if (halt) begin
               instrValid_d = 1'b0;
               if (canAccept && !ihit) begin
                  pendHalt_d = 1'b1;
                  state_d    = DRAIN;
               end else begin
                  state_d = HALTED;
               end
            end else if (redir_valid) begin
               instrValid_d = 1'b0;
               if (canAccept && !ihit) begin
                  pendPc_d = redirAligned;
                  state_d  = DRAIN;
               end else begin
                  pc_d = redirAligned;
               end
            end else if (ihit && canAccept) begin
               instr_d      = imemload;
               instrValid_d = 1'b1;
               pc_d         = pc_q + word_t'(WORD_BYTES);
            end else if (consumed) begin
               instrValid_d = 1'b0;
            end
         end

         DRAIN: begin
            imemREN      = 1'b1;
            instrValid_d = 1'b0;
            if (redir_valid) begin
               pendPc_d = redirAligned;
            end
            if (halt) begin
               pendHalt_d = 1'b1;
            end
            // The returning word belongs to the abandoned stream, so drop it.
            if (ihit) begin
               pc_d    = pendPc_d;
               state_d = pendHalt_d ? HALTED : FETCH;
            end
         end

         HALTED: begin
            instrValid_d = 1'b0;
         end

         default: begin
            state_d = BOOT;
         end
      endcase
   end

endmodule
